// File: rtl/conv_ctrl_pkg.sv
// Shared types, widths and the configuration legality check for the
// convolution frame sequencer.
package conv_ctrl_pkg;

    localparam int unsigned MAX_KERNAL_DEF = 3;
    localparam int unsigned X_MAX_DEF      = 16;
    localparam int unsigned Y_MAX_DEF      = 16;
    localparam int unsigned TIMEOUT_DEF    = 64;

    localparam int unsigned KW = 8;
    localparam int unsigned XW = $clog2(X_MAX_DEF) + 1;
    localparam int unsigned YW = $clog2(Y_MAX_DEF) + 1;
    localparam int unsigned CW = $clog2(X_MAX_DEF) + $clog2(Y_MAX_DEF) + 2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        FILL    = 3'd2,
        OFFER   = 3'd3,
        ADVANCE = 3'd4,
        DONE    = 3'd5
    } ctrl_state_t;

    // Odd kernel within limits and a non-empty frame within the image bounds.
    function automatic logic cfg_legal(
        input logic [KW-1:0] k,
        input logic [XW-1:0] mx,
        input logic [YW-1:0] my,
        input int unsigned   k_max,
        input int unsigned   x_max,
        input int unsigned   y_max
    );
        return (k != '0) && k[0] && (32'(k) <= k_max)
            && (mx != '0) && (32'(mx) <= x_max)
            && (my != '0) && (32'(my) <= y_max);
    endfunction

endpackage

// File: rtl/conv_frame_ctrl_if.sv
// Sequencer-side bundle: conv_memory/pixel_pos control plus the window
// valid/ready handshake toward the convolution engine.
interface conv_frame_ctrl_if;
    import conv_ctrl_pkg::*;

    logic [KW-1:0] kernel_size;
    logic [XW-1:0] max_x;
    logic [YW-1:0] max_y;
    logic          new_trans;
    logic          new_sample_req;
    logic          new_sample_ready;
    logic          win_valid;
    logic          win_ready;

    modport master (
        output kernel_size, max_x, max_y, new_trans, new_sample_req, win_valid,
        input  new_sample_ready, win_ready
    );

    modport slave (
        input  kernel_size, max_x, max_y, new_trans, new_sample_req, win_valid,
        output new_sample_ready, win_ready
    );
endinterface

// File: rtl/conv_ctrl_wdog.sv
// FILL-state watchdog: counts enabled cycles since the last clear and flags
// when the count reaches TIMEOUT-1 so the FSM leaves on the TIMEOUT-th edge.
module conv_ctrl_wdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire_c
);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] cnt_q, cnt_d;

    assign expire_c = en && (cnt_q == TW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expire_c) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame-level sequencer for the Gaussian convolution front end.
// Optional FILL watchdog and timeout_err port enabled by CONV_TIMEOUT_EN.
module conv_frame_ctrl
    import conv_ctrl_pkg::*;
#(
`ifdef CONV_TIMEOUT_EN
    parameter int unsigned TIMEOUT    = TIMEOUT_DEF,
`endif
    parameter int unsigned MAX_KERNAL = MAX_KERNAL_DEF,
    parameter int unsigned X_MAX      = X_MAX_DEF,
    parameter int unsigned Y_MAX      = Y_MAX_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    input  logic [KW-1:0]           cfg_kernel_size,
    input  logic [XW-1:0]           cfg_max_x,
    input  logic [YW-1:0]           cfg_max_y,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    cfg_err,
    output logic [CW-1:0]           pix_count,
`ifdef CONV_TIMEOUT_EN
    output logic                    timeout_err,
`endif
    conv_frame_ctrl_if.master       mem
);

    ctrl_state_t   state_q, state_d;

    logic          ready_q;
    logic [KW-1:0] kernel_q, kernel_d;
    logic [XW-1:0] max_x_q, max_x_d;
    logic [YW-1:0] max_y_q, max_y_d;
    logic [CW-1:0] total_q, total_d;
    logic [CW-1:0] pix_q, pix_d;

    logic new_trans_q, new_trans_d;
    logic req_q, req_d;
    logic win_valid_q, win_valid_d;
    logic busy_q, busy_d;
    logic frame_done_q, frame_done_d;
    logic cfg_err_q, cfg_err_d;

    logic ready_rise_c;
    logic legal_c;
    logic start_ok_c;
    logic handshake_c;
    logic last_c;
    logic timeout_c;

    assign ready_rise_c = mem.new_sample_ready && !ready_q;
    assign legal_c      = cfg_legal(cfg_kernel_size, cfg_max_x, cfg_max_y,
                                    MAX_KERNAL, X_MAX, Y_MAX);
    assign start_ok_c   = (state_q == IDLE) && start && !abort && legal_c;
    assign handshake_c  = (state_q == OFFER) && mem.win_ready && !abort;
    assign last_c       = (pix_q == total_q - CW'(1));

`ifdef CONV_TIMEOUT_EN
    logic timeout_err_q, timeout_err_d;

    conv_ctrl_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .clr      ((state_d == FILL) && (state_q != FILL)),
        .en       (state_q == FILL),
        .expire_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // Next-state logic; abort overrides every transition.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok_c) state_d = START;
            START:   state_d = FILL;
            FILL: begin
                if (ready_rise_c)   state_d = OFFER;
                else if (timeout_c) state_d = IDLE;
            end
            OFFER:   if (mem.win_ready) state_d = last_c ? DONE : ADVANCE;
            ADVANCE: state_d = FILL;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
        end
    end

    // Outputs decoded from the next state so the registered copies line up
    // with the state they belong to.
    always_comb begin
        new_trans_d  = 1'b0;
        req_d        = 1'b0;
        win_valid_d  = 1'b0;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;
        unique case (state_d)
            START:   begin new_trans_d = 1'b1; busy_d = 1'b1; end
            FILL:    busy_d = 1'b1;
            OFFER:   begin win_valid_d = 1'b1; busy_d = 1'b1; end
            ADVANCE: begin req_d = 1'b1; busy_d = 1'b1; end
            DONE:    frame_done_d = 1'b1;
            default: ;
        endcase
        cfg_err_d = (state_q == IDLE) && start && !abort && !legal_c;
`ifdef CONV_TIMEOUT_EN
        timeout_err_d = (state_q == FILL) && timeout_c && !ready_rise_c && !abort;
`endif
    end

    // Config latch, frame total (multiplied once in START) and window count.
    always_comb begin
        kernel_d = kernel_q;
        max_x_d  = max_x_q;
        max_y_d  = max_y_q;
        total_d  = total_q;
        pix_d    = pix_q;
        if (start_ok_c) begin
            kernel_d = cfg_kernel_size;
            max_x_d  = cfg_max_x;
            max_y_d  = cfg_max_y;
            pix_d    = '0;
        end
        if (state_q == START) begin
            total_d = CW'(max_x_q) * CW'(max_y_q);
        end
        if (handshake_c) begin
            pix_d = pix_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b0;
            kernel_q     <= '0;
            max_x_q      <= '0;
            max_y_q      <= '0;
            total_q      <= '0;
            pix_q        <= '0;
            new_trans_q  <= 1'b0;
            req_q        <= 1'b0;
            win_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= mem.new_sample_ready;
            kernel_q     <= kernel_d;
            max_x_q      <= max_x_d;
            max_y_q      <= max_y_d;
            total_q      <= total_d;
            pix_q        <= pix_d;
            new_trans_q  <= new_trans_d;
            req_q        <= req_d;
            win_valid_q  <= win_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

`ifdef CONV_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`endif

    assign mem.kernel_size    = kernel_q;
    assign mem.max_x          = max_x_q;
    assign mem.max_y          = max_y_q;
    assign mem.new_trans      = new_trans_q;
    assign mem.new_sample_req = req_q;
    assign mem.win_valid      = win_valid_q;
    assign busy               = busy_q;
    assign frame_done         = frame_done_q;
    assign cfg_err            = cfg_err_q;
    assign pix_count          = pix_q;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Directed bench for conv_frame_ctrl with a conv_memory stand-in and a
// window scoreboard; timeout scenario compiled in with CONV_TIMEOUT_EN.
module tb_conv_frame_ctrl;
    import conv_ctrl_pkg::*;

    localparam int FILL_LAT = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [KW-1:0] cfg_k;
    logic [XW-1:0] cfg_x;
    logic [YW-1:0] cfg_y;
    logic          busy;
    logic          frame_done;
    logic          cfg_err;
    logic [CW-1:0] pix_count;
`ifdef CONV_TIMEOUT_EN
    logic          timeout_err;
`endif

    conv_frame_ctrl_if bus ();

    conv_frame_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .cfg_kernel_size (cfg_k),
        .cfg_max_x       (cfg_x),
        .cfg_max_y       (cfg_y),
        .busy            (busy),
        .frame_done      (frame_done),
        .cfg_err         (cfg_err),
        .pix_count       (pix_count),
`ifdef CONV_TIMEOUT_EN
        .timeout_err     (timeout_err),
`endif
        .mem             (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    int exp_q[$];

    int n_trans = 0, n_req = 0, n_done = 0, n_hs = 0, n_to = 0;
    int trans_cyc = 0, hs_cyc = -10, done_cyc = 0, to_cyc = 0, lat_bad = 0;
    int stall_win = -1, stall_len = 0, held = 0, req_in_stall = 0;
    bit mem_en = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // conv_memory stand-in: on new_trans/new_sample_req drop ready, then raise
    // it FILL_LAT cycles later and record which window becomes available.
    initial begin : mem_model
        int win_idx;
        win_idx = 0;
        bus.new_sample_ready = 1'b0;
        bus.win_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (mem_en && (bus.new_trans || bus.new_sample_req)) begin
                if (bus.new_trans) begin
                    win_idx = 0;
                    exp_q.delete();
                end else begin
                    win_idx++;
                end
                bus.new_sample_ready = 1'b0;
                repeat (FILL_LAT) @(negedge clk);
                exp_q.push_back(win_idx);
                bus.new_sample_ready = 1'b1;
                if (win_idx == stall_win) begin
                    bus.win_ready = 1'b0;
                    repeat (stall_len) begin
                        @(negedge clk);
                        if (bus.win_valid) held++;
                        if (bus.new_sample_req) req_in_stall++;
                    end
                    bus.win_ready = 1'b1;
                end
            end
        end
    end

    // Event monitor and window scoreboard, sampled after the negedge drivers.
    initial begin : monitor
        int e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                if (bus.new_trans) begin n_trans++; trans_cyc = cyc; end
                if (bus.new_sample_req) begin
                    n_req++;
                    if (cyc != hs_cyc + 1) lat_bad++;
                end
                if (frame_done) begin n_done++; done_cyc = cyc; end
                if (bus.win_valid && bus.win_ready && !abort) begin
                    n_hs++;
                    hs_cyc = cyc;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    chk("sb_pix", 32'(pix_count), e);
                end
`ifdef CONV_TIMEOUT_EN
                if (timeout_err) begin n_to++; to_cyc = cyc; end
`endif
            end
        end
    end

    task automatic pulse_start(input int k, input int x, input int y, input logic ab);
        @(negedge clk);
        cfg_k = KW'(k);
        cfg_x = XW'(x);
        cfg_y = YW'(y);
        start = 1'b1;
        abort = ab;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic run_frame(input int k, input int x, input int y, input string tag);
        int t0, r0, h0, d0, l0, s_cyc, guard;
        t0 = n_trans; r0 = n_req; h0 = n_hs; d0 = n_done; l0 = lat_bad;
        @(negedge clk);
        cfg_k = KW'(k); cfg_x = XW'(x); cfg_y = YW'(y);
        start = 1'b1;
        s_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        guard = 0;
        while (n_done == d0 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_no_hang"}, 32'(guard < 5000), 1);
        chk({tag, "_trans_lat"}, trans_cyc, s_cyc + 1);
        chk({tag, "_trans"}, n_trans - t0, 1);
        chk({tag, "_reqs"}, n_req - r0, x * y - 1);
        chk({tag, "_windows"}, n_hs - h0, x * y);
        chk({tag, "_pix_count"}, 32'(pix_count), x * y);
        chk({tag, "_done_lat"}, done_cyc, hs_cyc + 1);
        chk({tag, "_req_lat"}, lat_bad - l0, 0);
        chk({tag, "_kernel"}, 32'(bus.kernel_size), k);
        chk({tag, "_max_x"}, 32'(bus.max_x), x);
        chk({tag, "_max_y"}, 32'(bus.max_y), y);
    endtask

    task automatic bad_cfg(input int k, input int x, input int y, input int pk, input int px,
                           input string tag);
        int t0;
        t0 = n_trans;
        pulse_start(k, x, y, 1'b0);
        chk({tag, "_cfg_err"}, 32'(cfg_err), 1);
        chk({tag, "_busy"}, 32'(busy), 0);
        repeat (3) @(negedge clk);
        chk({tag, "_no_trans"}, n_trans - t0, 0);
        chk({tag, "_kernel_kept"}, 32'(bus.kernel_size), pk);
        chk({tag, "_max_x_kept"}, 32'(bus.max_x), px);
        chk({tag, "_err_pulse"}, 32'(cfg_err), 0);
    endtask

    initial begin : stimulus
        int guard, t0, d0;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_k = '0; cfg_x = '0; cfg_y = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_win_valid", 32'(bus.win_valid), 0);
        chk("rst_new_trans", 32'(bus.new_trans), 0);
        chk("rst_pix_count", 32'(pix_count), 0);
        chk("rst_kernel", 32'(bus.kernel_size), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_frame(3, 5, 5, "f5x5");

        stall_win = 7; stall_len = 10; held = 0; req_in_stall = 0;
        run_frame(3, 9, 9, "f9x9");
        chk("stall_held", held, 10);
        chk("stall_no_req", req_in_stall, 0);
        stall_win = -1;

        bad_cfg(4, 5, 5, 3, 9, "k4");
        bad_cfg(0, 5, 5, 3, 9, "k0");
        bad_cfg(2, 5, 5, 3, 9, "k2");
        bad_cfg(3, 17, 5, 3, 9, "x17");
        bad_cfg(3, 5, 0, 3, 9, "y0");

        t0 = n_trans;
        pulse_start(1, 2, 2, 1'b1);
        chk("abort_start_err", 32'(cfg_err), 0);
        repeat (2) @(negedge clk);
        chk("abort_start_trans", n_trans - t0, 0);
        chk("abort_start_busy", 32'(busy), 0);

        // 16x16 frame aborted after 100 windows.
        d0 = n_done;
        pulse_start(3, 16, 16, 1'b0);
        guard = 0;
        while (n_hs < 81 + 25 + 100 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("abort_reach_100", 32'(guard < 5000), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_win_valid", 32'(bus.win_valid), 0);
        chk("abort_pix_hold", 32'(pix_count), 100);
        repeat (10) @(negedge clk);
        chk("abort_no_done", n_done - d0, 0);

        run_frame(3, 4, 4, "f4x4");

        // start while busy, then rst mid-frame.
        t0 = n_trans;
        d0 = n_done;
        pulse_start(3, 5, 5, 1'b0);
        guard = 0;
        while (n_hs < 81 + 25 + 100 + 16 + 3 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        pulse_start(1, 2, 2, 1'b0);
        repeat (4) @(negedge clk);
        chk("busy_start_trans", n_trans - t0, 1);
        chk("busy_start_kernel", 32'(bus.kernel_size), 3);
        chk("busy_start_max_x", 32'(bus.max_x), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_outs", {busy, frame_done, cfg_err, bus.new_trans, bus.new_sample_req,
                            bus.win_valid, pix_count, bus.kernel_size, bus.max_x, bus.max_y}, 0);
        repeat (8) @(negedge clk);
        chk("midrst_no_done", n_done - d0, 0);

        run_frame(1, 1, 1, "f1x1");

`ifdef CONV_TIMEOUT_EN
        mem_en = 1'b0;
        @(negedge clk);
        bus.new_sample_ready = 1'b0;
        t0 = n_to;
        pulse_start(1, 2, 2, 1'b0);
        guard = 0;
        while (n_to == t0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("to_fired", n_to - t0, 1);
        chk("to_latency", to_cyc, trans_cyc + 65);
        chk("to_busy", 32'(busy), 0);
        chk("to_win_valid", 32'(bus.win_valid), 0);
        mem_en = 1'b1;
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit");
    end

endmodule
